sdram_req_arb: RTL and testbench
================================

Name: sdram_req_arb

Overview:
- Request arbiter directly upstream of the SDRAM controller. Merges a ROM/loader byte-write stream with a CPU byte-read port.
- Drives the controller's read port (level rd, rd_rdy completion) and its write port (toggle we_req/we_ack handshake, byte-write flag).
- Buffers loader writes in a FIFO so that load traffic never stalls on refresh slots.
- Bounds write priority so that pending CPU reads are not starved.

Parameters:
- FIFO_DEPTH, 8, loader write FIFO entries; power of two, 2..64.
- RD_STARVE, 4, max consecutive writes issued while a CPU read is pending; after that the read wins.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- reset_n  in  1  asynchronous active-low reset.
- ld_wr  in  1  one-cycle loader write strobe.
- ld_addr  in  25  loader byte address.
- ld_data  in  8  loader byte.
- ld_busy  out  1  FIFO full; loader must not strobe while high.
- ld_ovf  out  1  sticky; set when ld_wr arrives while full; cleared only by reset.
- cpu_rd  in  1  one-cycle read request strobe.
- cpu_addr  in  25  CPU byte address, sampled with cpu_rd.
- cpu_dout  out  8  read data.
- cpu_rdy  out  1  high when idle or data valid; low while a read is outstanding.
- sd_raddr  out  25  controller read address.
- sd_rd  out  1  controller read request (level).
- sd_rd_rdy  in  1  controller read-ready.
- sd_dout  in  8  controller read byte.
- sd_waddr  out  25  controller write address.
- sd_din  out  16  controller write data.
- sd_we  out  1  byte-write flag (1 = single byte, lane chosen by sd_waddr[0]).
- sd_we_req  out  1  write request toggle.
- sd_we_ack  in  1  write acknowledge toggle.

Behaviour:
- Reset values: ld_busy 0, ld_ovf 0, cpu_dout 0, cpu_rdy 1, sd_rd 0, sd_raddr 0, sd_waddr 0, sd_din 0, sd_we 0, sd_we_req 0. FIFO empty, starvation counter 0, state IDLE.
- Reset mid-operation: all state is abandoned. The controller may still toggle sd_we_ack once afterwards. Arbiter therefore resynchronises on the first IDLE cycle after reset: sd_we_req <= sd_we_ack when the two differ, with no write issued that cycle.
- FIFO entry is {addr[24:0], data[7:0], we_flag}.
- Push on ld_wr when not full. Push while full is dropped and sets ld_ovf.
- ld_busy is registered: high when the count equals FIFO_DEPTH, or equals FIFO_DEPTH-1 with a push and no pop in the same cycle.
- Simultaneous push and pop when full is legal; the count is unchanged.
- cpu_rd with cpu_rdy=1: latch cpu_addr, set rd_pend, cpu_rdy <= 0 next cycle.
- cpu_rd with cpu_rdy=0: ignored.
- States:
  - IDLE: if a write is pending and (no rd_pend, or starve count < RD_STARVE), pop the head and go to WR. Else if rd_pend, go to RD_ISS. Else stay.
  - WR: on entry, sd_waddr/sd_din/sd_we load from the popped entry and sd_we_req toggles. Increment the starve count if rd_pend. Return to IDLE when sd_we_ack == sd_we_req.
  - RD_ISS: sd_raddr <= latched addr, sd_rd <= 1. Go to RD_WAIT when sd_rd_rdy == 0. Starve count clears.
  - RD_WAIT: on sd_rd_rdy == 1, sd_rd <= 0, cpu_dout <= sd_dout, cpu_rdy <= 1, rd_pend cleared, go to IDLE.
- Read latency from cpu_rd to cpu_rdy is at least 3 clk plus the controller slot time. cpu_dout holds its value until the next completion.
- Starve count saturates at RD_STARVE and resets to 0 whenever rd_pend is 0.
- Byte mode (macro undefined): each FIFO entry issues one write with sd_we=1, sd_din={data,data}.

Optional Feature:
- Macro SDRAM_ARB_WORD_PACK_EN.
- Defined: in IDLE, if the head entry has even addr A, the next entry has addr A+1, and both are present, pop both and issue one word write: sd_we=0, sd_din={odd_byte,even_byte}, sd_waddr=A. The pair counts as one write for starvation.
- Defined, but the even head is alone: wait up to 4 clk for its partner, unless rd_pend is set or the FIFO is full. Then issue it as a byte write.
- Undefined: pure byte mode; no pairing logic is present.

Test Plan:
- Reset, then ld_wr bytes 0x11@0x000100, 0x22@0x000101 (macro off) -> two writes; sd_we=1, sd_din=0x1111 then 0x2222; sd_we_req toggles twice; FIFO empties.
- Same stimulus with SDRAM_ARB_WORD_PACK_EN -> one write; sd_we=0, sd_waddr=0x000100, sd_din=0x2211.
- FIFO_DEPTH=8, stall sd_we_ack, 10 ld_wr -> ld_busy high after entry 8; ld_ovf=1; after the ack resumes, exactly 8 writes are issued.
- 12 queued writes plus cpu_rd@0x0000FF with RD_STARVE=4 -> read issued after exactly 4 writes; cpu_dout = model byte; cpu_rdy rises, remaining 8 writes follow.
- cpu_rd while cpu_rdy=0 -> ignored; sd_raddr keeps the first address.
- reset_n low while WR awaits ack, controller toggles ack after release -> no spurious write; sd_we_req equals sd_we_ack before the next issue.

Source files
------------

// File: rtl/sdram_req_arb.sv
// sdram_req_arb: merges a loader byte-write FIFO and a CPU byte-read port onto one SDRAM controller.
// Latency: a queued write issues 1 clk after it reaches the FIFO head; a CPU read takes >=3 clk plus controller slot time.
// Backpressure: ld_busy while the FIFO is full, cpu_rdy low while a read is outstanding; SDRAM_ARB_WORD_PACK_EN pairs even/odd bytes.
module sdram_req_arb #(
    parameter int FIFO_DEPTH = 8,
    parameter int RD_STARVE  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_wr,
    input  logic [24:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_busy,
    output logic        ld_ovf,
    input  logic        cpu_rd,
    input  logic [24:0] cpu_addr,
    output logic [7:0]  cpu_dout,
    output logic        cpu_rdy,
    output logic [24:0] sd_raddr,
    output logic        sd_rd,
    input  logic        sd_rd_rdy,
    input  logic [7:0]  sd_dout,
    output logic [24:0] sd_waddr,
    output logic [15:0] sd_din,
    output logic        sd_we,
    output logic        sd_we_req,
    input  logic        sd_we_ack
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(RD_STARVE + 1);

    typedef enum logic [1:0] {IDLE, WR, RD_ISS, RD_WAIT} state_t;

    state_t          state, state_nx;
    logic [33:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, pop_n;
    logic [SW-1:0]   starve;
    logic [24:0]     rd_addr;
    logic            rd_pend;
    logic            full, push, pop1, pop2, pop_any, issue, resync, may_wr;
    logic [33:0]     head;
    logic [24:0]     wr_addr_nx;
    logic [15:0]     wr_din_nx;
    logic            wr_we_nx;

    // entry layout: {addr[24:0], data[7:0], we_flag}
    assign head    = mem[rd_ptr];
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop_any = pop1 | pop2;
    assign push    = ld_wr && (!full || pop_any);
    assign pop_n   = pop2 ? CW'(2) : (pop1 ? CW'(1) : CW'(0));
    assign may_wr  = (count != '0) && (!rd_pend || (starve < SW'(RD_STARVE)));

`ifdef SDRAM_ARB_WORD_PACK_EN
    logic [33:0] next_ent;
    logic [2:0]  wait_cnt;
    logic        pair_ok, hold_even;

    assign next_ent  = mem[rd_ptr + AW'(1)];
    assign pair_ok   = !head[9] && (count >= CW'(2)) && (next_ent[33:9] == head[33:9] + 25'd1);
    // a lone even byte waits briefly for its odd partner unless a read or a full FIFO needs service
    assign hold_even = !head[9] && (count == CW'(1)) && !rd_pend && !full && (wait_cnt < 3'd4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (state == IDLE && sd_we_req == sd_we_ack && may_wr && hold_even)
            wait_cnt <= wait_cnt + 3'd1;
        else
            wait_cnt <= '0;
    end
`endif

    always_comb begin
        state_nx   = state;
        pop1       = 1'b0;
        pop2       = 1'b0;
        issue      = 1'b0;
        resync     = 1'b0;
        wr_addr_nx = head[33:9];
        wr_din_nx  = {head[8:1], head[8:1]};
        wr_we_nx   = head[0];
        case (state)
            IDLE: begin
                // a mismatch here can only be a stale ack from before reset
                if (sd_we_req != sd_we_ack) begin
                    resync = 1'b1;
                end else if (may_wr) begin
`ifdef SDRAM_ARB_WORD_PACK_EN
                    if (pair_ok) begin
                        pop2      = 1'b1;
                        issue     = 1'b1;
                        wr_din_nx = {next_ent[8:1], head[8:1]};
                        wr_we_nx  = 1'b0;
                        state_nx  = WR;
                    end else if (!hold_even) begin
                        pop1     = 1'b1;
                        issue    = 1'b1;
                        state_nx = WR;
                    end
`else
                    pop1     = 1'b1;
                    issue    = 1'b1;
                    state_nx = WR;
`endif
                end else if (rd_pend) begin
                    state_nx = RD_ISS;
                end
            end
            WR:      if (sd_we_ack == sd_we_req) state_nx = IDLE;
            RD_ISS:  if (!sd_rd_rdy) state_nx = RD_WAIT;
            RD_WAIT: if (sd_rd_rdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ld_addr, ld_data, 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ld_busy <= 1'b0;
            ld_ovf  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop2) rd_ptr <= rd_ptr + AW'(2);
            else if (pop1) rd_ptr <= rd_ptr + AW'(1);
            count   <= count + CW'(push) - pop_n;
            ld_busy <= full || ((count == CW'(FIFO_DEPTH - 1)) && push && !pop_any);
            if (ld_wr && full && !pop_any) ld_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sd_waddr  <= '0;
            sd_din    <= '0;
            sd_we     <= 1'b0;
            sd_we_req <= 1'b0;
            sd_raddr  <= '0;
            sd_rd     <= 1'b0;
            starve    <= '0;
        end else begin
            state <= state_nx;
            if (resync) begin
                sd_we_req <= sd_we_ack;
            end else if (issue) begin
                sd_waddr  <= wr_addr_nx;
                sd_din    <= wr_din_nx;
                sd_we     <= wr_we_nx;
                sd_we_req <= ~sd_we_req;
            end
            if (state == RD_ISS) begin
                sd_raddr <= rd_addr;
                sd_rd    <= 1'b1;
            end else if (state == RD_WAIT && sd_rd_rdy) begin
                sd_rd <= 1'b0;
            end
            if (!rd_pend || state == RD_ISS)
                starve <= '0;
            else if (issue && starve != SW'(RD_STARVE))
                starve <= starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr  <= '0;
            rd_pend  <= 1'b0;
            cpu_rdy  <= 1'b1;
            cpu_dout <= '0;
        end else begin
            if (cpu_rd && cpu_rdy) begin
                rd_addr <= cpu_addr;
                rd_pend <= 1'b1;
                cpu_rdy <= 1'b0;
            end else if (state == RD_WAIT && sd_rd_rdy) begin
                rd_pend  <= 1'b0;
                cpu_rdy  <= 1'b1;
                cpu_dout <= sd_dout;
            end
        end
    end
endmodule

// File: tb/tb_sdram_req_arb.sv
// Directed bench for sdram_req_arb: write path, FIFO full/overflow, bounded read starvation, reset resync.
// The controller is modelled as a toggle-ack write responder and a level rd/rd_rdy read responder.
module tb_sdram_req_arb;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_wr;
    logic [24:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_busy, ld_ovf;
    logic        cpu_rd;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;
    logic [24:0] sd_raddr;
    logic        sd_rd;
    logic        sd_rd_rdy;
    logic [7:0]  sd_dout;
    logic [24:0] sd_waddr;
    logic [15:0] sd_din;
    logic        sd_we, sd_we_req;
    logic        sd_we_ack;

    always #5 clk = ~clk;

    sdram_req_arb #(.FIFO_DEPTH(8), .RD_STARVE(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy), .ld_ovf(ld_ovf),
        .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
        .sd_raddr(sd_raddr), .sd_rd(sd_rd), .sd_rd_rdy(sd_rd_rdy), .sd_dout(sd_dout),
        .sd_waddr(sd_waddr), .sd_din(sd_din), .sd_we(sd_we),
        .sd_we_req(sd_we_req), .sd_we_ack(sd_we_ack)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // write responder: acks two cycles after seeing a new request unless stalled
    logic        stall = 1'b1;
    int          kick_req = 0;
    int          kick_seen = 0;
    int          wdly = 0;
    int          wr_cnt = 0;
    logic [24:0] wa [64];
    logic [15:0] wd [64];
    logic        ww [64];

    initial begin
        sd_we_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (kick_req != kick_seen) begin
                kick_seen = kick_req;
                sd_we_ack = ~sd_we_ack;
            end else if (!stall && reset_n && (sd_we_req != sd_we_ack)) begin
                if (wdly == 2) begin
                    if (wr_cnt < 64) begin
                        wa[wr_cnt] = sd_waddr;
                        wd[wr_cnt] = sd_din;
                        ww[wr_cnt] = sd_we;
                    end
                    wr_cnt++;
                    sd_we_ack = ~sd_we_ack;
                    wdly = 0;
                end else begin
                    wdly++;
                end
            end else begin
                wdly = 0;
            end
        end
    end

    // read responder: drops rd_rdy on a new sd_rd, returns addr^0xA5 three cycles later
    int          rs = 0;
    int          rcnt = 0;
    int          rd_cnt = 0;
    int          rd_at_wr = 0;
    logic [24:0] rd_cap = '0;

    initial begin
        sd_rd_rdy = 1'b1;
        sd_dout   = 8'h00;
        forever begin
            @(posedge clk); #1;
            case (rs)
                0: if (sd_rd && reset_n) begin
                    sd_rd_rdy = 1'b0;
                    rd_cap    = sd_raddr;
                    rd_at_wr  = wr_cnt;
                    rd_cnt++;
                    rcnt = 0;
                    rs   = 1;
                end
                1: begin
                    rcnt++;
                    if (rcnt == 3) begin
                        sd_dout   = sd_raddr[7:0] ^ 8'hA5;
                        sd_rd_rdy = 1'b1;
                        rs        = 2;
                    end
                end
                default: if (!sd_rd) rs = 0;
            endcase
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [24:0] a, input logic [7:0] d);
        ld_wr = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_wr = 1'b0;
    endtask

    task automatic wait_wr(input int n, input string name);
        int k = 0;
        while (wr_cnt < n && k < 400) begin @(posedge clk); #1; k++; end
        check(name, 32'(wr_cnt), 32'(n));
    endtask

    typedef struct {
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        busy;
        logic        ovf;
    } vec_t;
    vec_t tv [12];

    initial begin
        int b, rb, np, k;
        tv[0]  = '{1'b1, 25'h1001, 8'hC0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 25'h1003, 8'hC1, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 25'h1005, 8'hC2, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 25'h1007, 8'hC3, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 25'h1009, 8'hC4, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 25'h100B, 8'hC5, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 25'h100D, 8'hC6, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 25'h100F, 8'hC7, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 25'h1011, 8'hC8, 1'b1, 1'b1};
        tv[9]  = '{1'b1, 25'h1013, 8'hC9, 1'b1, 1'b1};
        tv[10] = '{1'b0, 25'h0000, 8'h00, 1'b1, 1'b1};
        tv[11] = '{1'b0, 25'h0000, 8'h00, 1'b1, 1'b1};

        reset_n = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
        cpu_rd = 1'b0; cpu_addr = '0;
        cycles(3);
        check("rst_cpu_dout", 32'(cpu_dout), 32'h0);
        check("rst_cpu_rdy", 32'(cpu_rdy), 32'h1);
        check("rst_sd_rd", 32'(sd_rd), 32'h0);
        check("rst_sd_raddr", 32'(sd_raddr), 32'h0);
        check("rst_sd_waddr", 32'(sd_waddr), 32'h0);
        check("rst_sd_din", 32'(sd_din), 32'h0);
        check("rst_sd_we", 32'(sd_we), 32'h0);
        check("rst_sd_we_req", 32'(sd_we_req), 32'h0);
        check("rst_ld_busy", 32'(ld_busy), 32'h0);
        check("rst_ld_ovf", 32'(ld_ovf), 32'h0);
        reset_n = 1'b1;
        stall = 1'b0;
        cycles(2);

        // two adjacent bytes
        push(25'h000100, 8'h11);
        push(25'h000101, 8'h22);
`ifdef SDRAM_ARB_WORD_PACK_EN
        wait_wr(1, "pack_wr_count");
        check("pack_addr", 32'(wa[0]), 32'h100);
        check("pack_din", 32'(wd[0]), 32'h2211);
        check("pack_we", 32'(ww[0]), 32'h0);
        cycles(20);
        check("pack_no_extra", 32'(wr_cnt), 32'd1);
        check("pack_req_parity", 32'(sd_we_req), 32'h1);
`else
        wait_wr(2, "byte_wr_count");
        check("byte0_addr", 32'(wa[0]), 32'h100);
        check("byte0_din", 32'(wd[0]), 32'h1111);
        check("byte0_we", 32'(ww[0]), 32'h1);
        check("byte1_addr", 32'(wa[1]), 32'h101);
        check("byte1_din", 32'(wd[1]), 32'h2222);
        check("byte1_we", 32'(ww[1]), 32'h1);
        cycles(20);
        check("byte_no_extra", 32'(wr_cnt), 32'd2);
        check("byte_req_parity", 32'(sd_we_req), 32'h0);
`endif
        check("basic_req_eq_ack", 32'(sd_we_req), 32'(sd_we_ack));

        // FIFO fill and overflow behind a stalled write
        b = wr_cnt;
        stall = 1'b1;
        push(25'h002001, 8'hB0);
        cycles(4);
        check("ovf_blocker_pending", 32'(sd_we_req ^ sd_we_ack), 32'h1);
        for (int i = 0; i < 12; i++) begin
            ld_wr = tv[i].wr; ld_addr = tv[i].addr; ld_data = tv[i].data;
            @(posedge clk); #1;
            check($sformatf("vec%0d_busy", i), 32'(ld_busy), 32'(tv[i].busy));
            check($sformatf("vec%0d_ovf", i), 32'(ld_ovf), 32'(tv[i].ovf));
        end
        ld_wr = 1'b0;
        stall = 1'b0;
        wait_wr(b + 9, "ovf_wr_count");
        check("ovf_first_addr", 32'(wa[b+1]), 32'h1001);
        check("ovf_last_addr", 32'(wa[b+8]), 32'h100F);
        check("ovf_last_din", 32'(wd[b+8]), 32'hC7C7);
        cycles(20);
        check("ovf_no_extra", 32'(wr_cnt), 32'(b + 9));
        check("ovf_busy_clear", 32'(ld_busy), 32'h0);
        check("ovf_sticky", 32'(ld_ovf), 32'h1);

        // reset while a write waits for ack; stale ack arrives after release
        b = wr_cnt;
        stall = 1'b1;
        push(25'h003001, 8'h5C);
        cycles(4);
        check("rr_pending", 32'(sd_we_req ^ sd_we_ack), 32'h1);
        reset_n = 1'b0;
        cycles(2);
        check("rr_req_rst", 32'(sd_we_req), 32'h0);
        check("rr_ovf_rst", 32'(ld_ovf), 32'h0);
        check("rr_rdy_rst", 32'(cpu_rdy), 32'h1);
        reset_n = 1'b1;
        cycles(3);
        check("rr_sync_release", 32'(sd_we_req), 32'(sd_we_ack));
        kick_req++;
        cycles(4);
        check("rr_sync_stale_ack", 32'(sd_we_req), 32'(sd_we_ack));
        stall = 1'b0;
        cycles(10);
        check("rr_no_spurious", 32'(wr_cnt), 32'(b));
        push(25'h003003, 8'h6D);
        wait_wr(b + 1, "rr_wr_count");
        check("rr_addr", 32'(wa[b]), 32'h3003);
        check("rr_din", 32'(wd[b]), 32'h6D6D);
        cycles(6);
        check("rr_req_eq_ack", 32'(sd_we_req), 32'(sd_we_ack));

        // bounded write priority over a pending read, plus an ignored second read
        b = wr_cnt;
        rb = rd_cnt;
        stall = 1'b1;
        push(25'h004001, 8'h00);
        cycles(4);
        for (int i = 0; i < 8; i++) push(25'h004003 + 25'(2 * i), 8'(i + 1));
        check("st_busy_full", 32'(ld_busy), 32'h1);
        cpu_rd = 1'b1; cpu_addr = 25'h0000FF;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        check("st_rdy_low", 32'(cpu_rdy), 32'h0);
        cycles(2);
        cpu_rd = 1'b1; cpu_addr = 25'h001234;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        stall = 1'b0;
        np = 0;
        k = 0;
        while (np < 4 && k < 300) begin
            if (!ld_busy) begin
                ld_wr = 1'b1; ld_addr = 25'h004013 + 25'(2 * np); ld_data = 8'(8'h40 + np);
                np++;
            end
            @(posedge clk); #1;
            ld_wr = 1'b0;
            k++;
        end
        check("st_extra_pushed", 32'(np), 32'd4);
        k = 0;
        while (!cpu_rdy && k < 400) begin @(posedge clk); #1; k++; end
        check("st_rdy_back", 32'(cpu_rdy), 32'h1);
        check("st_rd_after_4", 32'(rd_at_wr), 32'(b + 5));
        check("st_rd_addr", 32'(rd_cap), 32'hFF);
        check("st_cpu_dout", 32'(cpu_dout), 32'h5A);
        wait_wr(b + 13, "st_wr_count");
        cycles(10);
        check("st_one_read", 32'(rd_cnt), 32'(rb + 1));
        check("st_raddr_kept", 32'(sd_raddr), 32'hFF);
        check("st_rd_low", 32'(sd_rd), 32'h0);
        check("st_no_ovf", 32'(ld_ovf), 32'h0);
        check("st_dout_held", 32'(cpu_dout), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
